// File: rtl/opnd_sel_pkg.sv
// Shared definitions for the operand-bus select generator: mux select
// encodings and the layout of one in-flight destination tracking slot.
package opnd_sel_pkg;

  // Select encodings for the 4:1 operand mux, in {S1,S0} order.
  typedef enum logic [1:0] {
    SEL_RF  = 2'b00,  // register-file read
    SEL_EX  = 2'b01,  // EX-stage result
    SEL_MEM = 2'b10,  // MEM-stage result
    SEL_IMM = 2'b11   // immediate
  } sel_e;

  // Slot record layout, MSB to LSB: {valid, addr[aw-1:0], load}.
  localparam int SLOT_META_W = 2;

  // Total slot width for a given register address width.
  function automatic int slot_w(input int aw);
    return aw + SLOT_META_W;
  endfunction

endpackage

// File: rtl/opnd_sel_ctrl_fwd_slot.sv
// One in-flight instruction tracking register (EX or MEM slot). Holds
// {valid, addr, load}; clear drops only the valid bit, load captures new
// contents, otherwise the slot holds. Provides a destination match output.
module fwd_slot
  import opnd_sel_pkg::*;
#(
  parameter int AW = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          clr,
  input  logic          en,
  input  logic          d_valid,
  input  logic [AW-1:0] d_addr,
  input  logic          d_load,
  input  logic [AW-1:0] cmp_addr,
  output logic          valid,
  output logic [AW-1:0] addr,
  output logic          is_load,
  output logic          match
);

  localparam int W = slot_w(AW);

  logic [W-1:0] slot_q;

  // Slot register: clear beats load, load beats hold.
  // NOTE: non-blocking assignments keep every flop updating from pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      slot_q <= '0;
    end else if (clr) begin
      slot_q[W-1] <= 1'b0;
    end else if (en) begin
      slot_q <= {d_valid, d_addr, d_load};
    end
  end

  assign valid   = slot_q[W-1];
  assign addr    = slot_q[AW:1];
  assign is_load = slot_q[0];
  assign match   = valid && (addr == cmp_addr);

endmodule

// File: rtl/opnd_sel_ctrl.sv
// Operand-bus select generator. Tracks the destinations of the EX and MEM
// in-flight instructions, chooses the forwarding path for the operand being
// decoded (zero latency, from registered state plus current inputs) and
// raises a load-use interlock.
module opnd_sel_ctrl
  import opnd_sel_pkg::*;
#(
  parameter int AW      = 4,
  parameter int PC_ADDR = 15,
  parameter int FWD_EN  = 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          ISSUE,
  input  logic [AW-1:0] SRC_ADDR,
  input  logic          USE_IMM,
  input  logic [AW-1:0] DST_ADDR,
  input  logic          DST_WE,
  input  logic          DST_LOAD,
  input  logic          STALL,
  input  logic          FLUSH,
  output logic          S0,
  output logic          S1,
  output logic          HAZARD
);

  localparam logic [AW-1:0] PC = AW'(PC_ADDR);
  localparam bit FWD = (FWD_EN != 0);

  logic          ex_valid, ex_is_load, ex_match;
  logic [AW-1:0] ex_addr;
  logic          mem_valid, mem_is_load, mem_match;
  logic [AW-1:0] mem_addr;
  logic          unused_mem;

  logic  shift_en;
  logic  m_ex, m_mem;
  logic  hazard;
  sel_e  sel;

  // Both slots shift whenever the pipe is not held; on a hazard the EX slot
  // takes a bubble because the new instruction's valid bit is suppressed.
  assign shift_en = !STALL;

  fwd_slot #(.AW(AW)) u_ex (
    .CLK      (CLK),
    .RST      (RST),
    .clr      (FLUSH),
    .en       (shift_en),
    .d_valid  (ISSUE && DST_WE && !hazard),
    .d_addr   (DST_ADDR),
    .d_load   (DST_LOAD),
    .cmp_addr (SRC_ADDR),
    .valid    (ex_valid),
    .addr     (ex_addr),
    .is_load  (ex_is_load),
    .match    (ex_match)
  );

  fwd_slot #(.AW(AW)) u_mem (
    .CLK      (CLK),
    .RST      (RST),
    .clr      (FLUSH),
    .en       (shift_en),
    .d_valid  (ex_valid),
    .d_addr   (ex_addr),
    .d_load   (ex_is_load),
    .cmp_addr (SRC_ADDR),
    .valid    (mem_valid),
    .addr     (mem_addr),
    .is_load  (mem_is_load),
    .match    (mem_match)
  );

  // The MEM slot's contents are only needed through its match output.
  assign unused_mem = ^{mem_addr, mem_is_load};

  // The PC is always read from the register file, never forwarded.
  assign m_ex  = ex_match  && (SRC_ADDR != PC);
  assign m_mem = mem_match && (SRC_ADDR != PC);

  // Priority select and load-use interlock; EX (youngest) beats MEM.
  // NOTE: every output gets a default first so no latch is inferred.
  always_comb begin
    sel    = SEL_RF;
    hazard = 1'b0;
    if (RST) begin
      sel    = SEL_RF;
    end else if (USE_IMM) begin
      sel    = SEL_IMM;
    end else if (m_ex && ex_is_load) begin
      sel    = SEL_RF;
      hazard = !FLUSH;
    end else if (m_ex) begin
      sel    = FWD ? SEL_EX : SEL_RF;
    end else if (m_mem && FWD) begin
      sel    = SEL_MEM;
    end
  end

  assign {S1, S0} = sel;
  assign HAZARD   = hazard;

endmodule

// File: tb/tb_opnd_sel_ctrl.sv
// Directed testbench for opnd_sel_ctrl. A forwarding build and a
// forwarding-disabled build share the same stimulus.
module tb_opnd_sel_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic       ISSUE, USE_IMM, DST_WE, DST_LOAD, STALL, FLUSH;
  logic [3:0] SRC_ADDR, DST_ADDR;
  logic       S0, S1, HAZARD;
  logic       nf_s0, nf_s1, nf_hazard;

  int checks = 0;
  int errors = 0;

  opnd_sel_ctrl #(.AW(4), .PC_ADDR(15), .FWD_EN(1)) dut (
    .CLK(CLK), .RST(RST), .ISSUE(ISSUE), .SRC_ADDR(SRC_ADDR), .USE_IMM(USE_IMM),
    .DST_ADDR(DST_ADDR), .DST_WE(DST_WE), .DST_LOAD(DST_LOAD), .STALL(STALL),
    .FLUSH(FLUSH), .S0(S0), .S1(S1), .HAZARD(HAZARD)
  );

  opnd_sel_ctrl #(.AW(4), .PC_ADDR(15), .FWD_EN(0)) dut_nf (
    .CLK(CLK), .RST(RST), .ISSUE(ISSUE), .SRC_ADDR(SRC_ADDR), .USE_IMM(USE_IMM),
    .DST_ADDR(DST_ADDR), .DST_WE(DST_WE), .DST_LOAD(DST_LOAD), .STALL(STALL),
    .FLUSH(FLUSH), .S0(nf_s0), .S1(nf_s1), .HAZARD(nf_hazard)
  );

  always #5 CLK = ~CLK;

  // Advance one clock; outputs are then looked at 1 time unit after the edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    ISSUE = 1'b0; DST_WE = 1'b0; DST_LOAD = 1'b0; DST_ADDR = '0;
    USE_IMM = 1'b0; STALL = 1'b0; FLUSH = 1'b0; SRC_ADDR = '0;
  endtask

  task automatic issue(input logic [3:0] dst, input logic we, input logic ld);
    ISSUE = 1'b1; DST_ADDR = dst; DST_WE = we; DST_LOAD = ld;
  endtask

  task automatic no_issue();
    ISSUE = 1'b0; DST_WE = 1'b0; DST_LOAD = 1'b0;
  endtask

  // Empty the pipe with two bubble cycles.
  task automatic drain();
    idle();
    step();
    step();
  endtask

  task automatic test_reset();
    drain();
    issue(4'd3, 1'b1, 1'b0);
    step();
    no_issue(); SRC_ADDR = 4'd3; #1;
    checks++; if ({S1,S0} !== 2'b01) begin errors++; $display("FAIL rst_pre sel got %b want 01", {S1,S0}); end
    RST = 1'b1; #1;
    checks++; if ({S1,S0} !== 2'b00) begin errors++; $display("FAIL rst_sel sel got %b want 00", {S1,S0}); end
    checks++; if (HAZARD !== 1'b0) begin errors++; $display("FAIL rst_hazard got %b want 0", HAZARD); end
    USE_IMM = 1'b1; #1;
    checks++; if ({S1,S0} !== 2'b00) begin errors++; $display("FAIL rst_imm sel got %b want 00", {S1,S0}); end
    USE_IMM = 1'b0;
    issue(4'd3, 1'b1, 1'b1);
    step();
    no_issue();
    RST = 1'b0; #1;
    checks++; if ({S1,S0} !== 2'b00) begin errors++; $display("FAIL rst_post sel got %b want 00", {S1,S0}); end
    checks++; if (HAZARD !== 1'b0) begin errors++; $display("FAIL rst_post_hazard got %b want 0", HAZARD); end
  endtask

  task automatic test_ex_forward();
    drain();
    issue(4'd5, 1'b1, 1'b0);
    step();
    issue(4'd9, 1'b0, 1'b0); SRC_ADDR = 4'd5; #1;
    checks++; if ({S1,S0} !== 2'b01) begin errors++; $display("FAIL ex_fwd sel got %b want 01", {S1,S0}); end
    checks++; if ({nf_s1,nf_s0} !== 2'b00) begin errors++; $display("FAIL nf_ex sel got %b want 00", {nf_s1,nf_s0}); end
    step();
    checks++; if ({S1,S0} !== 2'b10) begin errors++; $display("FAIL mem_fwd sel got %b want 10", {S1,S0}); end
    checks++; if ({nf_s1,nf_s0} !== 2'b00) begin errors++; $display("FAIL nf_mem sel got %b want 00", {nf_s1,nf_s0}); end
    SRC_ADDR = 4'd9; #1;
    checks++; if ({S1,S0} !== 2'b00) begin errors++; $display("FAIL no_we sel got %b want 00", {S1,S0}); end
    SRC_ADDR = 4'd5;
    step();
    checks++; if ({S1,S0} !== 2'b00) begin errors++; $display("FAIL retired sel got %b want 00", {S1,S0}); end
  endtask

  task automatic test_load_use();
    drain();
    issue(4'd7, 1'b1, 1'b1);
    step();
    issue(4'd8, 1'b1, 1'b0); SRC_ADDR = 4'd7; #1;
    checks++; if (HAZARD !== 1'b1) begin errors++; $display("FAIL lu_hazard got %b want 1", HAZARD); end
    checks++; if ({S1,S0} !== 2'b00) begin errors++; $display("FAIL lu_sel sel got %b want 00", {S1,S0}); end
    checks++; if (nf_hazard !== 1'b1) begin errors++; $display("FAIL nf_lu_hazard got %b want 1", nf_hazard); end
    step();
    no_issue(); #1;
    checks++; if ({S1,S0} !== 2'b10) begin errors++; $display("FAIL lu_next sel got %b want 10", {S1,S0}); end
    checks++; if (HAZARD !== 1'b0) begin errors++; $display("FAIL lu_next_hazard got %b want 0", HAZARD); end
    SRC_ADDR = 4'd8; #1;
    checks++; if ({S1,S0} !== 2'b00) begin errors++; $display("FAIL lu_dropped sel got %b want 00", {S1,S0}); end
    // A load result one stage older is picked up from MEM with no interlock.
    drain();
    issue(4'd7, 1'b1, 1'b1);
    step();
    issue(4'd1, 1'b1, 1'b0);
    step();
    no_issue(); SRC_ADDR = 4'd7; #1;
    checks++; if ({S1,S0} !== 2'b10 || HAZARD !== 1'b0) begin errors++; $display("FAIL lu_mem sel got %b hazard %b want 10 0", {S1,S0}, HAZARD); end
  endtask

  task automatic test_priority_pc();
    drain();
    issue(4'd2, 1'b1, 1'b0);
    step();
    issue(4'd2, 1'b1, 1'b0);
    step();
    no_issue(); SRC_ADDR = 4'd2; #1;
    checks++; if ({S1,S0} !== 2'b01) begin errors++; $display("FAIL both_match sel got %b want 01", {S1,S0}); end
    USE_IMM = 1'b1; #1;
    checks++; if ({S1,S0} !== 2'b11) begin errors++; $display("FAIL imm sel got %b want 11", {S1,S0}); end
    checks++; if ({nf_s1,nf_s0} !== 2'b11) begin errors++; $display("FAIL nf_imm sel got %b want 11", {nf_s1,nf_s0}); end
    USE_IMM = 1'b0;
    drain();
    issue(4'd15, 1'b1, 1'b0);
    step();
    no_issue(); SRC_ADDR = 4'd15; #1;
    checks++; if ({S1,S0} !== 2'b00) begin errors++; $display("FAIL pc_ex sel got %b want 00", {S1,S0}); end
    drain();
    issue(4'd15, 1'b1, 1'b1);
    step();
    no_issue(); SRC_ADDR = 4'd15; #1;
    checks++; if (HAZARD !== 1'b0) begin errors++; $display("FAIL pc_load_hazard got %b want 0", HAZARD); end
    drain();
    issue(4'd2, 1'b1, 1'b1);
    step();
    no_issue(); SRC_ADDR = 4'd2; USE_IMM = 1'b1; #1;
    checks++; if ({S1,S0} !== 2'b11 || HAZARD !== 1'b0) begin errors++; $display("FAIL imm_load sel got %b hazard %b want 11 0", {S1,S0}, HAZARD); end
    USE_IMM = 1'b0;
  endtask

  task automatic test_stall_flush();
    drain();
    issue(4'd6, 1'b1, 1'b0);
    step();
    no_issue(); SRC_ADDR = 4'd6; STALL = 1'b1; #1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if ({S1,S0} !== 2'b01) begin errors++; $display("FAIL stall_hold cycle %0d sel got %b want 01", i, {S1,S0}); end
    end
    STALL = 1'b0;
    issue(4'd4, 1'b1, 1'b0); FLUSH = 1'b1;
    step();
    no_issue(); FLUSH = 1'b0; SRC_ADDR = 4'd4; #1;
    checks++; if ({S1,S0} !== 2'b00) begin errors++; $display("FAIL flush_issue sel got %b want 00", {S1,S0}); end
    SRC_ADDR = 4'd6; #1;
    checks++; if ({S1,S0} !== 2'b00) begin errors++; $display("FAIL flush_mem sel got %b want 00", {S1,S0}); end
    // A flush in the hazard cycle masks the interlock.
    issue(4'd7, 1'b1, 1'b1);
    step();
    no_issue(); SRC_ADDR = 4'd7; FLUSH = 1'b1; #1;
    checks++; if (HAZARD !== 1'b0) begin errors++; $display("FAIL flush_hazard got %b want 0", HAZARD); end
    step();
    FLUSH = 1'b0;
    issue(4'd10, 1'b1, 1'b0);
    step();
    issue(4'd11, 1'b1, 1'b0);
    step();
    no_issue(); STALL = 1'b1; FLUSH = 1'b1;
    step();
    STALL = 1'b0; FLUSH = 1'b0; SRC_ADDR = 4'd11; #1;
    checks++; if ({S1,S0} !== 2'b00) begin errors++; $display("FAIL stall_flush_ex sel got %b want 00", {S1,S0}); end
    SRC_ADDR = 4'd10; #1;
    checks++; if ({S1,S0} !== 2'b00) begin errors++; $display("FAIL stall_flush_mem sel got %b want 00", {S1,S0}); end
  endtask

  initial begin
    idle();
    RST = 1'b1;
    step();
    step();
    RST = 1'b0;
    #1;
    checks++; if ({S1,S0} !== 2'b00 || HAZARD !== 1'b0) begin errors++; $display("FAIL init sel got %b hazard %b want 00 0", {S1,S0}, HAZARD); end
    test_reset();
    test_ex_forward();
    test_load_use();
    test_priority_pc();
    test_stall_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
